// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helper functions
// Contents:
//   state_t        receiver FSM states
//   DATA_WD_DEF    default number of data bits per frame
//   START_BIT      line level of the start bit
//   STOP_BIT       line level of the stop bit
//   parity_bit()   expected parity bit for a data word (shared with the transmitter)
//   majority3()    2-of-3 vote used by the optional majority sampler
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int   DATA_WD_DEF   = 8;
    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;

    // Callers zero-extend their word to this width; zero padding does not
    // change the XOR reduction, so one function serves any DATA_WD <= 32.
    localparam int   PARITY_MAX_WD = 32;

    // odd = 0: even parity (bit makes the total count of ones even)
    // odd = 1: odd parity
    function automatic logic parity_bit(input logic [PARITY_MAX_WD-1:0] data,
                                        input logic                     odd);
        return odd ? ~^data : ^data;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter and sample strobe for uart_rx
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority sampling).
// Ports:
//   clk           oversampling clock
//   rst_n         asynchronous active-low reset
//   run           1 while the receiver is inside a frame; 0 holds the counter at 0
//   rx_s          synchronized serial line
//   prescale      clocks per bit (latched by the FSM for the whole frame)
//   sample_valid  strobe: sample_bit holds the decided value of the current bit
//   sample_bit    decided bit value
//   bit_end       strobe: last clock of the current bit
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WD = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   rx_s,
    input  logic [PRESCALE_WD-1:0] prescale,
    output logic                   sample_valid,
    output logic                   sample_bit,
    output logic                   bit_end
);

    localparam logic [PRESCALE_WD-1:0] ONE = PRESCALE_WD'(1);

    logic [PRESCALE_WD-1:0] edge_cnt;
    logic [PRESCALE_WD-1:0] half;
    logic [PRESCALE_WD-1:0] last;

    assign half = prescale >> 1;
    assign last = prescale - ONE;

    // Held at 0 outside a frame so the first START clock is edge_cnt == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (!run) begin
            edge_cnt <= '0;
        end else if (edge_cnt == last) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    assign bit_end = run && (edge_cnt == last);

`ifdef UART_RX_MAJORITY_EN
    logic s_early;
    logic s_mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else if (run) begin
            if (edge_cnt == half - ONE) begin
                s_early <= rx_s;
            end
            if (edge_cnt == half) begin
                s_mid <= rx_s;
            end
        end
    end

    // Third sample is the live line value at half+1; the vote is decided there.
    assign sample_valid = run && (edge_cnt == half + ONE);
    assign sample_bit   = majority3(s_early, s_mid, rx_s);
`else
    assign sample_valid = run && (edge_cnt == half);
    assign sample_bit   = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, DATA_WD data bits LSB first, optional parity, stop
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority sampling, sample point +1 clock).
// Ports:
//   CLK         oversampling clock
//   RST         asynchronous active-low reset
//   RX_IN       serial line, asynchronous to CLK, idles high
//   PRESCALE    clocks per bit (even, 4..32)
//   PAR_EN      1 = parity bit present
//   PAR_TYP     0 = even, 1 = odd
//   P_DATA      last correctly received byte
//   DATA_VALID  one-cycle pulse: P_DATA updated
//   PAR_ERR     one-cycle pulse: parity mismatch
//   STP_ERR     one-cycle pulse: stop bit sampled 0
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WD     = DATA_WD_DEF,
    parameter int PRESCALE_WD = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic [PRESCALE_WD-1:0] PRESCALE,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic [DATA_WD-1:0]     P_DATA,
    output logic                   DATA_VALID,
    output logic                   PAR_ERR,
    output logic                   STP_ERR
);

    localparam int BIT_CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
    localparam logic [BIT_CNT_WD-1:0] LAST_BIT = BIT_CNT_WD'(DATA_WD - 1);
    localparam logic [BIT_CNT_WD-1:0] BIT_ONE  = BIT_CNT_WD'(1);

    logic                   sync1;
    logic                   sync2;
    logic                   rx_s;

    state_t                 state;
    logic [DATA_WD-1:0]     shift_reg;
    logic [BIT_CNT_WD-1:0]  bit_cnt;
    logic                   par_fail;
    logic [PRESCALE_WD-1:0] lat_prescale;
    logic                   lat_par_en;
    logic                   lat_par_typ;

    logic                   run;
    logic                   sample_valid;
    logic                   sample_bit;
    logic                   bit_end;
    logic                   stop_bad;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= RX_IN;
            sync2 <= sync1;
        end
    end

    assign rx_s = sync2;
    assign run  = (state != IDLE);

    uart_rx_sampler #(
        .PRESCALE_WD (PRESCALE_WD)
    ) u_sampler (
        .clk          (CLK),
        .rst_n        (RST),
        .run          (run),
        .rx_s         (rx_s),
        .prescale     (lat_prescale),
        .sample_valid (sample_valid),
        .sample_bit   (sample_bit),
        .bit_end      (bit_end)
    );

    assign stop_bad = (sample_bit != STOP_BIT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            par_fail     <= 1'b0;
            lat_prescale <= '0;
            lat_par_en   <= 1'b0;
            lat_par_typ  <= 1'b0;
            P_DATA       <= '0;
            DATA_VALID   <= 1'b0;
            PAR_ERR      <= 1'b0;
            STP_ERR      <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_s == START_BIT) begin
                        state        <= START;
                        bit_cnt      <= '0;
                        par_fail     <= 1'b0;
                        lat_prescale <= PRESCALE;
                        lat_par_en   <= PAR_EN;
                        lat_par_typ  <= PAR_TYP;
                    end
                end

                START: begin
                    // A start bit that is high again at the sample point was a glitch.
                    if (sample_valid && (sample_bit != START_BIT)) begin
                        state <= IDLE;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (sample_valid) begin
                        shift_reg[bit_cnt] <= sample_bit;
                    end
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= lat_par_en ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                end

                PARITY: begin
                    if (sample_valid) begin
                        par_fail <= (sample_bit !=
                                     parity_bit(PARITY_MAX_WD'(shift_reg), lat_par_typ));
                    end
                    if (bit_end) begin
                        state <= STOP;
                    end
                end

                STOP: begin
                    // Leave at the sample point rather than the bit end so a start
                    // edge directly following the stop bit is caught in IDLE.
                    if (sample_valid) begin
                        state <= IDLE;
                        if (par_fail || stop_bad) begin
                            PAR_ERR <= par_fail;
                            STP_ERR <= stop_bad;
                        end else begin
                            P_DATA     <= shift_reg;
                            DATA_VALID <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
